// File: rtl/cu_seq_if.sv
// Bundle of the cu_seq control, RAM and ALU signals.
// Handshake: the requester raises start with opcode/dest/src stable; the
// sequencer samples start only while idle (busy=0), and the sample edge
// accepts the instruction. busy then stays high up to and including the
// single done cycle, and err is meaningful only while done=1. start seen
// while busy is dropped, not queued.
// The master modport is the sequencer side; the slave modport is the
// requester / RAM / ALU side.
interface cu_seq_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic                start;
  logic [3:0]          opcode;
  logic [ADDR_W-1:0]   dest;
  logic [ADDR_W-1:0]   src;
  logic                busy;
  logic                done;
  logic                err;
  logic                flag_z;
  logic                flag_c;
  logic                mem_rd;
  logic                mem_wr;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic [3:0]          alu_op;
  logic [DATA_W-1:0]   alu_a;
  logic [DATA_W-1:0]   alu_b;
  logic [2*DATA_W-1:0] alu_result;
  logic                alu_zero;

  modport master (
    input  start, opcode, dest, src, mem_rdata, alu_result, alu_zero,
    output busy, done, err, flag_z, flag_c, mem_rd, mem_wr, mem_addr,
           mem_wdata, alu_op, alu_a, alu_b
  );

  modport slave (
    output start, opcode, dest, src, mem_rdata, alu_result, alu_zero,
    input  busy, done, err, flag_z, flag_c, mem_rd, mem_wr, mem_addr,
           mem_wdata, alu_op, alu_a, alu_b
  );
endinterface

// File: rtl/cu_seq.sv
// Multi-cycle control sequencer: runs one register-to-register instruction
// per start handshake over an external synchronous-read RAM and a
// combinational ALU, keeps registered Z/C flags and reports illegal opcodes.
module cu_seq #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  cu_seq_if.master   bus,
  output logic [2:0] state_o
);

  localparam logic [3:0] OP_MOV = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0100;
  localparam logic [3:0] OP_OR  = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_LT  = 4'b1010;
  localparam logic [3:0] OP_EQ  = 4'b1011;
  localparam logic [3:0] OP_MVI = 4'b1100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_RD_B = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          op_q;
  logic [ADDR_W-1:0]   dest_q, src_q;
  logic [DATA_W-1:0]   opa_q, res_q;
  logic                err_q, flag_z_q, flag_c_q;

  logic                start_ok, illegal_in;
  logic                is_mov, is_mvi, is_bin, is_addsub;

  logic                busy, done_pulse, err_out;
  logic                rd_strobe, wr_strobe;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata, a_opnd, b_opnd;
  logic [3:0]          alu_code;

  assign start_ok   = (state_q == S_IDLE) && bus.start;
  assign illegal_in = (bus.opcode == 4'd0) || (bus.opcode > OP_MVI);
  assign is_mov     = (op_q == OP_MOV);
  assign is_mvi     = (op_q == OP_MVI);
  assign is_bin     = op_q inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LT, OP_EQ};
  assign is_addsub  = (op_q == OP_ADD) || (op_q == OP_SUB);

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Instruction capture, operand A, ALU result and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      dest_q   <= '0;
      src_q    <= '0;
      err_q    <= 1'b0;
      opa_q    <= '0;
      res_q    <= '0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
    end else begin
      if (start_ok) begin
        op_q   <= bus.opcode;
        dest_q <= bus.dest;
        src_q  <= bus.src;
        err_q  <= illegal_in;
      end
      if (state_q == S_RD_B) opa_q <= bus.mem_rdata;
      if (state_q == S_EXEC) begin
        res_q    <= bus.alu_result[DATA_W-1:0];
        flag_z_q <= bus.alu_zero;
        // Only ADD/SUB define a carry/borrow; other ops keep the old C.
        if (is_addsub) flag_c_q <= bus.alu_result[DATA_W];
      end
    end
  end

  // Next state and per-state RAM/ALU strobes; everything idles at zero.
  always_comb begin
    state_d    = state_q;
    rd_strobe  = 1'b0;
    wr_strobe  = 1'b0;
    addr       = '0;
    wdata      = '0;
    a_opnd     = '0;
    b_opnd     = '0;
    alu_code   = 4'd0;
    done_pulse = 1'b0;
    err_out    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (illegal_in)                 state_d = S_DONE;
          else if (bus.opcode == OP_MVI)  state_d = S_WB;
          else                            state_d = S_RD_A;
        end
      end
      S_RD_A: begin
        rd_strobe = 1'b1;
        addr      = is_mov ? src_q : dest_q;
        state_d   = is_mov ? S_WB : S_RD_B;
      end
      S_RD_B: begin
        if (is_bin) begin
          rd_strobe = 1'b1;
          addr      = src_q;
        end
        state_d = S_EXEC;
      end
      S_EXEC: begin
        a_opnd   = opa_q;
        b_opnd   = is_bin ? bus.mem_rdata : '0;
        // ALU codes run 1..10 for opcodes ADD..EQ, i.e. opcode minus one.
        alu_code = op_q - 4'd1;
        state_d  = S_WB;
      end
      S_WB: begin
        wr_strobe = 1'b1;
        addr      = dest_q;
        if (is_mov)      wdata = bus.mem_rdata;
        else if (is_mvi) wdata = DATA_W'(src_q);
        else             wdata = res_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        done_pulse = 1'b1;
        err_out    = err_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy = (state_q != S_IDLE);

  assign bus.busy      = busy;
  assign bus.done      = done_pulse;
  assign bus.err       = err_out;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.mem_rd    = rd_strobe;
  assign bus.mem_wr    = wr_strobe;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.alu_op    = alu_code;
  assign bus.alu_a     = a_opnd;
  assign bus.alu_b     = b_opnd;
  assign state_o       = state_q;

endmodule

// File: tb/tb_cu_seq.sv
// Bench for cu_seq: a 16-bit and an 8-bit instance, each with a RAM and ALU
// model, driven from a table of directed instructions plus hand sequences
// for held start and mid-instruction reset.
module tb_cu_seq;

  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_LT  = 4'd10;
  localparam logic [3:0] OP_EQ  = 4'd11;
  localparam logic [3:0] OP_MVI = 4'd12;

  typedef struct {
    logic        sel;   // 0: 16-bit instance, 1: 8-bit instance
    logic [3:0]  op;
    logic [5:0]  d;
    logic [5:0]  s;
    logic        pre;   // preload mem[d]=pd then mem[s]=ps
    logic [15:0] pd;
    logic [15:0] ps;
    logic [15:0] ev;    // expected mem[d] afterwards
    int          lat;   // expected edges from T to done cycle
    logic        er;
    logic        z;
    logic        c;
    int          rd;    // expected read strobes
    int          wr;    // expected write strobes
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cu_seq_if #(.DATA_W(16), .ADDR_W(6)) if16();
  cu_seq_if #(.DATA_W(8),  .ADDR_W(4)) if8();
  logic [2:0] st16, st8;

  cu_seq #(.DATA_W(16), .ADDR_W(6)) dut16 (
    .clk(clk), .rst_n(rst_n), .bus(if16.master), .state_o(st16)
  );
  cu_seq #(.DATA_W(8), .ADDR_W(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .bus(if8.master), .state_o(st8)
  );

  // ---------------- ALU model ----------------
  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input int w);
    logic [31:0] m, ax, bx, r;
    m  = (32'd1 << w) - 32'd1;
    ax = {16'd0, a} & m;
    bx = {16'd0, b} & m;
    case (op)
      4'd1:    r = ax + bx;
      4'd2:    r = ax - bx;
      4'd3:    r = ax & bx;
      4'd4:    r = ax | bx;
      4'd5:    r = ax ^ bx;
      4'd6:    r = ~ax & m;
      4'd7:    r = (ax << 1) & m;
      4'd8:    r = ax >> 1;
      4'd9:    r = {31'd0, ax < bx};
      4'd10:   r = {31'd0, ax == bx};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  logic [31:0] r16, r8;
  assign r16 = alu_f(if16.alu_op, if16.alu_a, if16.alu_b, 16);
  assign if16.alu_result = r16;
  assign if16.alu_zero   = (r16[15:0] == 16'd0);
  assign r8  = alu_f(if8.alu_op, {8'd0, if8.alu_a}, {8'd0, if8.alu_b}, 8);
  assign if8.alu_result  = r8[15:0];
  assign if8.alu_zero    = (r8[7:0] == 8'd0);

  // ---------------- RAM models with backdoor preload ----------------
  logic [15:0] mem16[64];
  logic [7:0]  mem8[16];
  logic        bd_we16 = 1'b0, bd_we8 = 1'b0;
  logic [5:0]  bd_a16;
  logic [3:0]  bd_a8;
  logic [15:0] bd_d16;
  logic [7:0]  bd_d8;

  always @(posedge clk) begin
    if (bd_we16)          mem16[bd_a16] <= bd_d16;
    else if (if16.mem_wr) mem16[if16.mem_addr] <= if16.mem_wdata;
    if (if16.mem_rd)      if16.mem_rdata <= mem16[if16.mem_addr];
  end

  always @(posedge clk) begin
    if (bd_we8)           mem8[bd_a8] <= bd_d8;
    else if (if8.mem_wr)  mem8[if8.mem_addr] <= if8.mem_wdata;
    if (if8.mem_rd)       if8.mem_rdata <= mem8[if8.mem_addr];
  end

  // Strobe counters and rd/wr overlap monitor.
  int rd16 = 0, wr16 = 0, rd8 = 0, wr8 = 0, both = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (if16.mem_rd) rd16 <= rd16 + 1;
      if (if16.mem_wr) wr16 <= wr16 + 1;
      if (if8.mem_rd)  rd8  <= rd8 + 1;
      if (if8.mem_wr)  wr8  <= wr8 + 1;
      if ((if16.mem_rd && if16.mem_wr) || (if8.mem_rd && if8.mem_wr)) both <= both + 1;
    end
  end

  // Views of the currently selected instance.
  logic cur;
  wire  busy_s = cur ? if8.busy   : if16.busy;
  wire  done_s = cur ? if8.done   : if16.done;
  wire  err_s  = cur ? if8.err    : if16.err;
  wire  z_s    = cur ? if8.flag_z : if16.flag_z;
  wire  c_s    = cur ? if8.flag_c : if16.flag_c;
  wire  logic [6:0] ctl16 = {if16.busy, if16.done, if16.err, if16.flag_z,
                             if16.flag_c, if16.mem_rd, if16.mem_wr};
  wire  logic [6:0] ctl8  = {if8.busy, if8.done, if8.err, if8.flag_z,
                             if8.flag_c, if8.mem_rd, if8.mem_wr};

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] peek(input logic sel, input logic [5:0] a);
    if (sel) return {8'd0, mem8[a[3:0]]};
    return mem16[a];
  endfunction

  // ---------------- driver tasks ----------------
  task automatic preload(input logic sel, input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    if (sel) begin bd_we8 = 1'b1; bd_a8 = a[3:0]; bd_d8 = d[7:0]; end
    else     begin bd_we16 = 1'b1; bd_a16 = a; bd_d16 = d; end
    @(posedge clk);
    #1;
    bd_we8  = 1'b0;
    bd_we16 = 1'b0;
  endtask

  task automatic drive_start(input logic sel, input logic [3:0] op,
                             input logic [5:0] d, input logic [5:0] s);
    if (sel) begin
      if8.start = 1'b1; if8.opcode = op; if8.dest = d[3:0]; if8.src = s[3:0];
    end else begin
      if16.start = 1'b1; if16.opcode = op; if16.dest = d; if16.src = s;
    end
  endtask

  // Issue one instruction and measure edges from the sampling edge to done.
  task automatic run_instr(input logic sel, input logic [3:0] op, input logic [5:0] d,
                           input logic [5:0] s, output int lat, output logic er,
                           output logic busy_ok);
    @(negedge clk);
    cur = sel;
    drive_start(sel, op, d, s);
    @(posedge clk);
    #1;
    if8.start  = 1'b0;
    if16.start = 1'b0;
    lat = 0; er = 1'b0; busy_ok = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (!busy_s) busy_ok = 1'b0;
      if (done_s) begin
        lat = k;
        er  = err_s;
        break;
      end
    end
  endtask

  task automatic apply_vec(input int i, input vec_t v);
    int lat, rd0, wr0;
    logic er, bok;
    if (v.pre) begin
      preload(v.sel, v.d, v.pd);
      preload(v.sel, v.s, v.ps);
    end
    rd0 = v.sel ? rd8 : rd16;
    wr0 = v.sel ? wr8 : wr16;
    run_instr(v.sel, v.op, v.d, v.s, lat, er, bok);
    chk($sformatf("v%0d_latency", i), lat, v.lat);
    chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, v.er});
    chk($sformatf("v%0d_busy", i), {31'd0, bok}, 32'd1);
    chk($sformatf("v%0d_result", i), {16'd0, peek(v.sel, v.d)}, {16'd0, v.ev});
    chk($sformatf("v%0d_flag_z", i), {31'd0, z_s}, {31'd0, v.z});
    chk($sformatf("v%0d_flag_c", i), {31'd0, c_s}, {31'd0, v.c});
    chk($sformatf("v%0d_reads", i), (v.sel ? rd8 : rd16) - rd0, v.rd);
    chk($sformatf("v%0d_writes", i), (v.sel ? wr8 : wr16) - wr0, v.wr);
  endtask

  function automatic vec_t mk(input logic sel, input logic [3:0] op, input logic [5:0] d,
                              input logic [5:0] s, input logic pre, input logic [15:0] pd,
                              input logic [15:0] ps, input logic [15:0] ev, input int lat,
                              input logic er, input logic z, input logic c,
                              input int rd, input int wr);
    vec_t v;
    v.sel = sel; v.op = op; v.d = d; v.s = s; v.pre = pre; v.pd = pd; v.ps = ps;
    v.ev = ev; v.lat = lat; v.er = er; v.z = z; v.c = c; v.rd = rd; v.wr = wr;
    return v;
  endfunction

  vec_t vt[20];

  // ---------------- test sequence ----------------
  initial begin
    int lat, rd0, wr0;
    vec_t sv;

    rst_n = 1'b0;
    cur   = 1'b0;
    if16.start = 1'b0; if16.opcode = '0; if16.dest = '0; if16.src = '0;
    if8.start  = 1'b0; if8.opcode  = '0; if8.dest  = '0; if8.src  = '0;

    //        sel op       d   s   pre pd       ps       ev       lat er z c rd wr
    vt[0]  = mk(0, OP_MVI,  5, 42, 1, 16'hDEAD, 16'h0000, 16'h002A, 2, 0, 0, 0, 0, 1);
    vt[1]  = mk(0, OP_MOV,  6,  5, 0, 16'h0000, 16'h0000, 16'h002A, 3, 0, 0, 0, 1, 1);
    vt[2]  = mk(0, OP_ADD,  1,  2, 1, 16'hFFFF, 16'h0001, 16'h0000, 5, 0, 1, 1, 2, 1);
    vt[3]  = mk(0, OP_SUB,  2,  2, 0, 16'h0000, 16'h0000, 16'h0000, 5, 0, 1, 0, 2, 1);
    vt[4]  = mk(0, 4'hE,    3,  4, 1, 16'h1234, 16'h5678, 16'h1234, 1, 1, 1, 0, 0, 0);
    vt[5]  = mk(0, OP_AND,  7,  8, 1, 16'hF0F0, 16'h3C3C, 16'h3030, 5, 0, 0, 0, 2, 1);
    vt[6]  = mk(0, OP_OR,   9, 10, 1, 16'h1200, 16'h0034, 16'h1234, 5, 0, 0, 0, 2, 1);
    vt[7]  = mk(0, OP_XOR, 11, 12, 1, 16'hAAAA, 16'hAAAA, 16'h0000, 5, 0, 1, 0, 2, 1);
    vt[8]  = mk(0, OP_NOT, 13, 14, 1, 16'h00FF, 16'h9999, 16'hFF00, 5, 0, 0, 0, 1, 1);
    vt[9]  = mk(0, OP_SHR, 15, 16, 1, 16'h8001, 16'h0000, 16'h4000, 5, 0, 0, 0, 1, 1);
    vt[10] = mk(0, OP_LT,  16, 17, 1, 16'h0005, 16'h0009, 16'h0001, 5, 0, 0, 0, 2, 1);
    vt[11] = mk(0, OP_EQ,  18, 19, 1, 16'h0007, 16'h0007, 16'h0001, 5, 0, 0, 0, 2, 1);
    vt[12] = mk(0, OP_SUB, 20, 21, 1, 16'h0003, 16'h0005, 16'hFFFE, 5, 0, 0, 1, 2, 1);
    vt[13] = mk(0, OP_MOV, 23, 24, 1, 16'h0000, 16'hBEEF, 16'hBEEF, 3, 0, 0, 1, 1, 1);
    vt[14] = mk(0, 4'h0,   25, 26, 1, 16'h0ABC, 16'h0000, 16'h0ABC, 1, 1, 0, 1, 0, 0);
    vt[15] = mk(0, OP_MVI, 27, 63, 1, 16'hFFFF, 16'h0000, 16'h003F, 2, 0, 0, 1, 0, 1);
    vt[16] = mk(0, OP_ADD, 22, 22, 1, 16'h4000, 16'h4000, 16'h8000, 5, 0, 0, 0, 2, 1);
    vt[17] = mk(1, OP_ADD,  3,  4, 1, 16'h00C8, 16'h0064, 16'h002C, 5, 0, 0, 1, 2, 1);
    vt[18] = mk(1, OP_LT,   0,  1, 1, 16'h0003, 16'h00C8, 16'h0001, 5, 0, 0, 1, 2, 1);
    vt[19] = mk(1, OP_MVI,  2, 15, 1, 16'h00AA, 16'h0000, 16'h000F, 2, 0, 0, 1, 0, 1);

    // Outputs and state while reset is asserted.
    #3;
    chk("reset_ctl16", {25'd0, ctl16}, 32'd0);
    chk("reset_addr16", {26'd0, if16.mem_addr}, 32'd0);
    chk("reset_wdata16", {16'd0, if16.mem_wdata}, 32'd0);
    chk("reset_alu16", {12'd0, if16.alu_op, if16.alu_a}, 32'd0);
    chk("reset_state16", {29'd0, st16}, 32'd0);
    chk("reset_ctl8", {25'd0, ctl8}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) apply_vec(i, vt[i]);

    // start held high through a whole SHL: exactly one execution.
    preload(1'b0, 6'd4, 16'h8001);
    rd0 = rd16;
    wr0 = wr16;
    @(negedge clk);
    cur = 1'b0;
    drive_start(1'b0, OP_SHL, 6'd4, 6'd5);
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (if16.done) begin
        lat = k;
        break;
      end
    end
    if16.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("shl_latency", lat, 5);
    chk("shl_result", {16'd0, peek(1'b0, 6'd4)}, 32'h0002);
    chk("shl_writes", wr16 - wr0, 1);
    chk("shl_reads", rd16 - rd0, 1);
    chk("shl_idle_after", {31'd0, if16.busy}, 32'd0);
    chk("shl_flags", {30'd0, if16.flag_z, if16.flag_c}, 32'd0);

    // Borrow leaves C=1 so the reset below has a nonzero flag to clear.
    sv = mk(0, OP_SUB, 28, 29, 1, 16'h0000, 16'h0001, 16'hFFFF, 5, 0, 0, 1, 2, 1);
    apply_vec(20, sv);

    // Reset asserted during RD_B of an ADD: abort, no write-back.
    preload(1'b0, 6'd26, 16'h1111);
    preload(1'b0, 6'd27, 16'h2222);
    wr0 = wr16;
    @(negedge clk);
    cur = 1'b0;
    drive_start(1'b0, OP_ADD, 6'd26, 6'd27);
    @(posedge clk);
    #1;
    if16.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_in_rd_b", {29'd0, st16}, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_ctl", {25'd0, ctl16}, 32'd0);
    chk("rst_mid_addr", {26'd0, if16.mem_addr}, 32'd0);
    chk("rst_mid_wdata", {16'd0, if16.mem_wdata}, 32'd0);
    chk("rst_mid_alu_ab", {if16.alu_a, if16.alu_b}, 32'd0);
    chk("rst_mid_alu_op", {28'd0, if16.alu_op}, 32'd0);
    chk("rst_mid_state", {29'd0, st16}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_mid_no_write", wr16 - wr0, 0);
    chk("rst_mid_mem", {16'd0, peek(1'b0, 6'd26)}, 32'h1111);
    chk("rst_mid_idle", {29'd0, st16}, 32'd0);

    chk("rd_wr_overlap", both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cu_seq.md
# cu_seq

Parametrised multi-cycle control sequencer for the CPU datapath. It executes one register-to-register instruction per `start` handshake by driving an external synchronous-read data RAM and a combinational ALU, then writing the result back. It sits between instruction fetch/decode and the RAM/ALU instances. It adds three things the first-generation control unit lacks: a start/busy/done handshake, registered Z/C flags, and illegal-opcode reporting.

## Interface
Parameters:
- `DATA_W`, 16: datapath and RAM word width.
- `ADDR_W`, 6: register/RAM address width; also the immediate width for MVI.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `start`, in, 1: request to execute the presented instruction; sampled only in IDLE.
- `opcode`, in, 4: instruction opcode; captured with `start`.
- `dest`, in, ADDR_W: destination/first-operand address; captured with `start`.
- `src`, in, ADDR_W: source address, or the immediate for MVI; captured with `start`.
- `busy`, out, 1: high while an instruction is in flight.
- `done`, out, 1: one-cycle completion pulse.
- `err`, out, 1: valid with `done`; high means an illegal opcode was received.
- `flag_z`, out, 1: registered zero flag.
- `flag_c`, out, 1: registered carry/borrow flag.
- `mem_rd`, out, 1: RAM read strobe.
- `mem_wr`, out, 1: RAM write strobe.
- `mem_addr`, out, ADDR_W: RAM address.
- `mem_wdata`, out, DATA_W: RAM write data.
- `mem_rdata`, in, DATA_W: RAM read data, valid the cycle after `mem_rd`.
- `alu_op`, out, 4: ALU operation code.
- `alu_a`, out, DATA_W: ALU operand A.
- `alu_b`, out, DATA_W: ALU operand B.
- `alu_result`, in, 2*DATA_W: ALU result, combinational.
- `alu_zero`, in, 1: ALU zero indication.

## Operation
- Opcodes:
  - 0001 MOV: dest = src.
  - 0010 ADD, 0011 SUB, 0100 AND, 0101 OR, 0110 XOR, 1010 LT, 1011 EQ: dest = dest op src.
  - 0111 NOT, 1000 SHL, 1001 SHR: dest = op dest.
  - 1100 MVI: dest = zero-extended `src`.
  - 0000 and 1101–1111: illegal.
- `alu_op` mapping, in opcode order ADD..EQ: ADD=1, SUB=2, AND=3, OR=4, XOR=5, NOT=6, SHL=7, SHR=8, LT=9, EQ=10. `alu_op` is 0 outside EXEC.
- States: IDLE, RD_A, RD_B, EXEC, WB, DONE.
- IDLE:
  - `start`=1 captures opcode/dest/src.
  - Illegal opcode → DONE with `err`=1.
  - MVI → WB.
  - Everything else → RD_A.
- RD_A: `mem_rd`=1. `mem_addr` = src for MOV, dest otherwise. MOV → WB; other opcodes → RD_B.
- RD_B: latch `mem_rdata` into operand A. For binary ops, `mem_rd`=1 and `mem_addr`=src. → EXEC.
- EXEC:
  - Binary ops latch `mem_rdata` into operand B; unary ops use B=0.
  - Drive `alu_a`/`alu_b`/`alu_op`.
  - Register `alu_result[DATA_W-1:0]`.
  - `flag_z` ← `alu_zero`.
  - `flag_c` ← `alu_result[DATA_W]` for ADD/SUB; `flag_c` is unchanged for other ops.
  - → WB.
- WB:
  - `mem_wr`=1, `mem_addr`=dest.
  - `mem_wdata` = registered result (ALU ops), `mem_rdata` (MOV), or {0, src} (MVI).
  - → DONE.
- DONE: `done`=1 for one cycle; `err` is valid this cycle only. → IDLE.
- MOV and MVI leave the flags unchanged. Illegal opcodes perform no memory access and leave the flags unchanged.
- `start` outside IDLE, including in the DONE cycle, is ignored and not queued.
- At most one of `mem_rd`/`mem_wr` is high in any cycle.

## Timing
- Reset values (async assert):
  - state IDLE.
  - `busy`, `done`, `err`, `flag_z`, `flag_c`, `mem_rd`, `mem_wr` = 0.
  - `mem_addr`, `mem_wdata`, `alu_a`, `alu_b`, `alu_op` = 0.
- Reset mid-instruction aborts immediately. No write occurs for the aborted instruction, even if WB was next.
- Latency counts from T, the edge that samples `start`, to the cycle in which `done` is high:
  - illegal: T+1.
  - MVI: WB at T+1, done T+2.
  - MOV: done T+3.
  - ALU ops: RD_A T+1, RD_B T+2, EXEC T+3, WB T+4, done T+5.
- `busy` is high from T+1 through the DONE cycle inclusive. The earliest next `start` is sampled in the cycle after DONE.
- RAM reads return data one cycle after the strobe.
- The write-back address equals `dest` even when `dest`=`src`. Operand A is read before any write, so for example ADD r3,r3 doubles r3.
- Widths:
  - Results are truncated to DATA_W.
  - SUB borrow: `flag_c`=1 when dest<src, unsigned.
  - LT and EQ write 1 or 0 zero-extended.

## Test plan
- Reset: drive ops, then pull `rst_n` low mid-RD_B → every output is 0 immediately; no `mem_wr` pulse follows; state is IDLE.
- MVI r5,#42 then MOV r6,r5 → r6=42; `done` at T+2 and T+3 respectively; flags unchanged.
- r1=0xFFFF, r2=0x0001, ADD r1,r2 → r1=0x0000, `flag_z`=1, `flag_c`=1, `done` at T+5. Then SUB r2,r2 → r2=0, `flag_z`=1, `flag_c`=0.
- Opcode 1110 → `done` and `err` at T+1, no `mem_rd`/`mem_wr`. The next legal op reports `err`=0.
- `start` held high continuously through a SHL r4 with r4=0x8001 → r4=0x0002. Exactly one instruction executes per IDLE visit; `start` during `busy` is ignored.
- DATA_W=8, ADDR_W=4 instance: LT r0,r1 with r0=3, r1=200 → r0=1; MVI with src=0xF → 0x0F.
